display_scanner: RTL and testbench

DISPLAY_SCANNER -- requirements
Module: display_scanner

---
 rtl/display_scanner_pkg.sv | 37 +++
 rtl/display_scanner_scan_timer.sv | 28 ++
 rtl/display_scanner.sv | 102 ++++++++++
 tb/tb_display_scanner.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/display_scanner_pkg.sv
// Shared types, constants and BCD helpers for the multiplexed four-digit display scanner.
package display_scanner_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    COMMIT = 2'd2
  } state_t;

  localparam logic [3:0]  BLANK_CODE = 4'hF;
  localparam int          NUM_DIGITS = 4;
  localparam logic [15:0] MAX_VALUE  = 16'd9999;

  // Double-dabble correction: every nibble >= 5 gets +3 before the shift.
  function automatic logic [15:0] dabble_adjust(input logic [15:0] bcd);
    logic [15:0] r;
    r = bcd;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (r[4*k +: 4] >= 4'd5) r[4*k +: 4] = r[4*k +: 4] + 4'd3;
    end
    return r;
  endfunction

  // Blanks zero digits above the most-significant nonzero one; digit 0 always shows.
  function automatic logic [15:0] blank_leading(input logic [15:0] bcd, input logic lz);
    logic [15:0] r;
    logic        leading;
    r       = bcd;
    leading = lz;
    for (int k = NUM_DIGITS - 1; k > 0; k--) begin
      if (leading && (r[4*k +: 4] == 4'd0)) r[4*k +: 4] = BLANK_CODE;
      else                                  leading     = 1'b0;
    end
    return r;
  endfunction

endpackage

// File: rtl/display_scanner_scan_timer.sv
// Free-running scan prescaler: step is high in the last prescaler cycle, index advances on that edge.
module scan_timer #(
  parameter int SCAN_DIV = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  output logic [1:0] index,
  output logic       step
);

  logic [15:0] count;

  assign step = (count == 16'(SCAN_DIV - 1));

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
      index <= '0;
    end else if (step) begin
      count <= '0;
      index <= index + 2'd1;
    end else begin
      count <= count + 16'd1;
    end
  end

endmodule

// File: rtl/display_scanner.sv
// Converts a 16-bit binary value to four BCD digits and scans them onto a multiplexed display.
module display_scanner
  import display_scanner_pkg::*;
#(
  parameter int SCAN_DIV = 50000,
  parameter bit LZ_BLANK = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] value,
  input  logic        load,
  output logic        busy,
  output logic        ovf,
  output logic [3:0]  bcd_out,
  output logic [3:0]  digit_en_n
);

  state_t      state;
  logic [15:0] bin;
  logic [15:0] scratch;
  logic [15:0] digits;
  logic [3:0]  iter;
  logic        ovf_pend;
  logic [1:0]  index;
  logic [1:0]  index_next;
  logic        step;
  logic [31:0] shifted;
  logic [15:0] commit_digits;
  logic [15:0] shown_next;

  scan_timer #(.SCAN_DIV(SCAN_DIV)) u_scan_timer (
    .clk   (clk),
    .rst_n (rst_n),
    .index (index),
    .step  (step)
  );

  // NOTE: every always_comb output is assigned on every path, so no latch can be inferred.
  always_comb begin
    shifted       = {dabble_adjust(scratch), bin} << 1;
    commit_digits = ovf_pend ? {NUM_DIGITS{BLANK_CODE}} : blank_leading(scratch, LZ_BLANK);
    index_next    = index + {1'b0, step};
    shown_next    = (state == COMMIT) ? commit_digits : digits;
  end

  // NOTE: the digit registers are reset to blank so the display is dark until the first commit.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      busy     <= 1'b0;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      bin      <= '0;
      scratch  <= '0;
      iter     <= '0;
      digits   <= {NUM_DIGITS{BLANK_CODE}};
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            busy <= 1'b1;
            if (value > MAX_VALUE) begin
              ovf_pend <= 1'b1;
              state    <= COMMIT;
            end else begin
              ovf_pend <= 1'b0;
              bin      <= value;
              scratch  <= '0;
              iter     <= '0;
              state    <= CONV;
            end
          end
        end
        CONV: begin
          scratch <= shifted[31:16];
          bin     <= shifted[15:0];
          iter    <= iter + 4'd1;
          if (iter == 4'd15) state <= COMMIT;
        end
        COMMIT: begin
          digits <= commit_digits;
          ovf    <= ovf_pend;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Looking at next-cycle digits and index lets a commit and a scan step land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bcd_out    <= BLANK_CODE;
      digit_en_n <= 4'b1110;
    end else begin
      bcd_out    <= shown_next[4*index_next +: 4];
      digit_en_n <= ~(4'b0001 << index_next);
    end
  end

endmodule

// File: tb/tb_display_scanner.sv
// Randomized bench for display_scanner: two instances (blanking on/off, different scan rates) vs a decimal model.
module tb_display_scanner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] value = '0;
  logic        load = 1'b0;

  logic       busy_a, ovf_a, busy_b, ovf_b;
  logic [3:0] bcd_a, en_a, bcd_b, en_b;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  display_scanner #(.SCAN_DIV(4), .LZ_BLANK(1'b1)) dut_a (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_a), .ovf(ovf_a), .bcd_out(bcd_a), .digit_en_n(en_a)
  );

  display_scanner #(.SCAN_DIV(5), .LZ_BLANK(1'b0)) dut_b (
    .clk(clk), .rst_n(rst_n), .value(value), .load(load),
    .busy(busy_b), .ovf(ovf_b), .bcd_out(bcd_b), .digit_en_n(en_b)
  );

  // ---------------- reference model ----------------
  int         edges = 0;
  bit         pend = 1'b0;
  int         pend_edge = 0;
  bit         m_ovf = 1'b0;
  bit         p_ovf = 1'b0;
  logic [3:0] m_dig [2][4];
  logic [3:0] p_dig [2][4];

  function automatic logic [3:0] exp_digit(int v, int k, bit lz);
    int p = 1;
    for (int j = 0; j < k; j++) p *= 10;
    if (v > 9999) return 4'hF;
    if (lz && k > 0 && v < p) return 4'hF;
    return 4'((v / p) % 10);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edges = 0;
      pend  = 1'b0;
      m_ovf = 1'b0;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k < 4; k++) m_dig[i][k] = 4'hF;
    end else begin
      edges = edges + 1;
      if (pend && edges == pend_edge) begin
        pend  = 1'b0;
        m_ovf = p_ovf;
        m_dig = p_dig;
      end else if (!pend && load) begin
        pend      = 1'b1;
        p_ovf     = (value > 16'd9999);
        pend_edge = edges + (p_ovf ? 1 : 17);
        for (int k = 0; k < 4; k++) begin
          p_dig[0][k] = exp_digit(int'(value), k, 1'b1);
          p_dig[1][k] = exp_digit(int'(value), k, 1'b0);
        end
      end
    end
  end

  function automatic logic [9:0] expected(int i);
    int idx;
    idx = (edges / ((i == 0) ? 4 : 5)) % 4;
    return {pend, m_ovf, m_dig[i][idx], ~(4'b0001 << idx)};
  endfunction

  function automatic logic [9:0] observed(int i);
    return (i == 0) ? {busy_a, ovf_a, bcd_a, en_a} : {busy_b, ovf_b, bcd_b, en_b};
  endfunction

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    load  = 1'b0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (observed(i) !== 10'b00_1111_1110) begin
        errors++;
        $display("FAIL reset dut%0d: busy/ovf/bcd/en got %b required %b", i, observed(i), 10'b00_1111_1110);
      end
    end
    rst_n = 1'b1;
  endtask

  // Loads v, optionally a second value v2 d2 cycles later, and compares every cycle for n cycles.
  task automatic test_load(input string tag, input int v, input int v2, input int d2,
                           input int n, input int exp_busy);
    int busy_cycles = 0;
    for (int c = 0; c < n; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (observed(i) !== expected(i)) begin
          errors++;
          $display("FAIL %s dut%0d cycle %0d: busy/ovf/bcd/en got %b required %b",
                   tag, i, c, observed(i), expected(i));
        end
      end
      if (busy_a) busy_cycles++;
      load = 1'b0;
      if (c == 0) begin
        load  = 1'b1;
        value = 16'(v);
      end else if (c == d2) begin
        load  = 1'b1;
        value = 16'(v2);
      end
    end
    load = 1'b0;
    checks++;
    if (busy_cycles !== exp_busy) begin
      errors++;
      $display("FAIL %s busy_length: got %0d cycles required %0d", tag, busy_cycles, exp_busy);
    end
  endtask

  task automatic test_basic();
    test_load("basic_1234", 1234, 0, -1, 45, 17);
  endtask

  task automatic test_leading_zeros();
    test_load("zero", 0, 0, -1, 45, 17);
    test_load("seven", 7, 0, -1, 45, 17);
  endtask

  task automatic test_overflow();
    test_load("ovf_10000", 10000, 0, -1, 30, 1);
    test_load("after_ovf_42", 42, 0, -1, 45, 17);
  endtask

  task automatic test_back_to_back();
    test_load("b2b_9999_5", 9999, 5, 3, 45, 17);
  endtask

  task automatic test_scan_order();
    logic [3:0] en_tab [4];
    logic [3:0] bcd_tab [4];
    int k;
    en_tab  = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
    bcd_tab = '{4'd4, 4'd3, 4'd2, 4'd1};
    test_load("scan_1234", 1234, 0, -1, 25, 17);
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      k = (edges / 4) % 4;
      checks++;
      if ({en_a, bcd_a} !== {en_tab[k], bcd_tab[k]}) begin
        errors++;
        $display("FAIL scan_order cycle %0d: en/bcd got %b/%h required %b/%h",
                 c, en_a, bcd_a, en_tab[k], bcd_tab[k]);
      end
    end
  endtask

  task automatic test_random();
    int v;
    for (int r = 0; r < 8; r++) begin
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 65535)) : int'($urandom_range(0, 9999));
      test_load($sformatf("random_%0d", v), v, 0, -1, 45, (v > 9999) ? 1 : 17);
    end
  endtask

  task automatic test_reset_abort();
    value = 16'd5678;
    load  = 1'b1;
    @(negedge clk);
    load = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (observed(i) !== 10'b00_1111_1110) begin
        errors++;
        $display("FAIL abort_reset dut%0d: busy/ovf/bcd/en got %b required %b", i, observed(i), 10'b00_1111_1110);
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        checks++;
        if (observed(i) !== expected(i)) begin
          errors++;
          $display("FAIL abort_no_commit dut%0d cycle %0d: got %b required %b", i, c, observed(i), expected(i));
        end
      end
    end
    test_load("reload_5678", 5678, 0, -1, 45, 17);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_leading_zeros();
    test_overflow();
    test_back_to_back();
    test_scan_order();
    test_random();
    test_reset_abort();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
